// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Bit positions refer to the 4-bit M-stage control bundle.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    BR_EX = 1'b1
  } state_t;

  localparam int MEM_READ_BIT = 1;
  localparam int BEQ_BIT      = 2;
  localparam int BNE_BIT      = 3;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// A clear takes priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // count register: reset/clear to zero, increment until all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use stalls, branch
// hold/redirect FSM and saturating performance counters.
module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic             uses_rt_IF_ID,
  input  logic [4:0]       Rt_ID_EX,
  input  logic [3:0]       signals_M_Controller,
  input  logic [3:0]       signals_M_ID_EX,
  input  logic             zero_ALU,
  input  logic [31:0]      offset_ID_EX,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_bubble,
  output logic             isBranch,
  output logic [31:0]      PC_offset,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t state_r;
  state_t next_state_s;
  logic   lu_s;
  logic   br_id_s;
  logic   br_ex_s;
  logic   taken_s;
  logic   lu_inc_s;
  logic   br_inc_s;
  logic   tk_inc_s;

  // hazard and branch-outcome terms
  always_comb begin
    lu_s = signals_M_ID_EX[MEM_READ_BIT] && (Rt_ID_EX != 5'd0) &&
           ((Rt_ID_EX == Rs_IF_ID) || (uses_rt_IF_ID && (Rt_ID_EX == Rt_IF_ID)));
    br_id_s = signals_M_Controller[BEQ_BIT] || signals_M_Controller[BNE_BIT];
    br_ex_s = signals_M_ID_EX[BEQ_BIT] || signals_M_ID_EX[BNE_BIT];
    taken_s = (signals_M_ID_EX[BEQ_BIT] && zero_ALU) ||
              (signals_M_ID_EX[BNE_BIT] && !zero_ALU);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state and output decode; reset forces a flushed, frozen front end
  always_comb begin
    next_state_s = RUN;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    isBranch     = 1'b0;
    PC_offset    = 32'd0;
    lu_inc_s     = 1'b0;
    br_inc_s     = 1'b0;
    tk_inc_s     = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            lu_inc_s     = 1'b1;
          end else if (br_id_s) begin
            // branch moves to EX; fetch holds until it resolves there
            pc_write     = 1'b0;
            IF_ID_Flush  = 1'b1;
            br_inc_s     = 1'b1;
            next_state_s = BR_EX;
          end else begin
            next_state_s = RUN;
          end
        end
        BR_EX: begin
          // a non-branch in EX here is a protocol violation and falls through
          if (br_ex_s && taken_s) begin
            isBranch    = 1'b1;
            PC_offset   = offset_ID_EX;
            IF_ID_Flush = 1'b1;
            tk_inc_s    = 1'b1;
          end else begin
            isBranch = 1'b0;
          end
          next_state_s = RUN;
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clear),
    .inc   (lu_inc_s),
    .count (load_use_cnt)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clear),
    .inc   (br_inc_s),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clear),
    .inc   (tk_inc_s),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_sequencer;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Rs_IF_ID, Rt_IF_ID, Rt_ID_EX;
  logic          uses_rt_IF_ID, zero_ALU, cnt_clear;
  logic [3:0]    signals_M_Controller, signals_M_ID_EX;
  logic [31:0]   offset_ID_EX;
  logic          pc_write, IF_ID_write, IF_ID_Flush, ID_EX_bubble, isBranch;
  logic [31:0]   PC_offset;
  logic [CW-1:0] load_use_cnt, branch_cnt, taken_cnt;

  typedef struct {
    string       name;
    logic [4:0]  ctl;  // {pc_write, IF_ID_write, IF_ID_Flush, ID_EX_bubble, isBranch}
    logic [31:0] off;
    logic [1:0]  lu, br, tk;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] C_DEF = 5'b11000;
  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_LU  = 5'b00010;
  localparam logic [4:0] C_BID = 5'b01100;
  localparam logic [4:0] C_TK  = 5'b11101;

  pipeline_hazard_sequencer #(.CNT_W(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Rs_IF_ID             (Rs_IF_ID),
    .Rt_IF_ID             (Rt_IF_ID),
    .uses_rt_IF_ID        (uses_rt_IF_ID),
    .Rt_ID_EX             (Rt_ID_EX),
    .signals_M_Controller (signals_M_Controller),
    .signals_M_ID_EX      (signals_M_ID_EX),
    .zero_ALU             (zero_ALU),
    .offset_ID_EX         (offset_ID_EX),
    .cnt_clear            (cnt_clear),
    .pc_write             (pc_write),
    .IF_ID_write          (IF_ID_write),
    .IF_ID_Flush          (IF_ID_Flush),
    .ID_EX_bubble         (ID_EX_bubble),
    .isBranch             (isBranch),
    .PC_offset            (PC_offset),
    .load_use_cnt         (load_use_cnt),
    .branch_cnt           (branch_cnt),
    .taken_cnt            (taken_cnt)
  );

  always #5 clk = ~clk;

  // monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] ctl;
      e = q.pop_front();
      ctl = {pc_write, IF_ID_write, IF_ID_Flush, ID_EX_bubble, isBranch};
      n_cmp++;
      if (ctl !== e.ctl) begin
        n_bad++;
        $display("FAIL %s ctl: got %b want %b", e.name, ctl, e.ctl);
      end
      n_cmp++;
      if (PC_offset !== e.off) begin
        n_bad++;
        $display("FAIL %s PC_offset: got %h want %h", e.name, PC_offset, e.off);
      end
      n_cmp++;
      if ({load_use_cnt, branch_cnt, taken_cnt} !== {e.lu, e.br, e.tk}) begin
        n_bad++;
        $display("FAIL %s counters lu/br/tk: got %0d/%0d/%0d want %0d/%0d/%0d",
                 e.name, load_use_cnt, branch_cnt, taken_cnt, e.lu, e.br, e.tk);
      end
    end
  end

  task automatic vec(input string name, input logic r, input logic clr,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] rtex, input logic [3:0] mctl,
                     input logic [3:0] mex, input logic z, input logic [31:0] off,
                     input logic [4:0] ectl, input logic [31:0] eoff,
                     input logic [1:0] elu, input logic [1:0] ebr, input logic [1:0] etk);
    exp_t e;
    rst = r; cnt_clear = clr; Rs_IF_ID = rs; Rt_IF_ID = rt; uses_rt_IF_ID = urt;
    Rt_ID_EX = rtex; signals_M_Controller = mctl; signals_M_ID_EX = mex;
    zero_ALU = z; offset_ID_EX = off;
    e.name = name; e.ctl = ectl; e.off = eoff; e.lu = elu; e.br = ebr; e.tk = etk;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cnt_clear = 1'b0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
    uses_rt_IF_ID = 1'b0; Rt_ID_EX = 5'd0; signals_M_Controller = 4'd0;
    signals_M_ID_EX = 4'd0; zero_ALU = 1'b0; offset_ID_EX = 32'd0;
    @(posedge clk);
    #1;
    //   name        rst clr rs  rt  urt rtex mctl     mex      z     off          ctl    off        lu br tk
    vec("rst0",     1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h0,   C_RST,32'h0,   2'd0,2'd0,2'd0);
    vec("rst1",     1'b1,1'b0,5'd5,5'd0,1'b0,5'd5,4'b0100,4'b0010,1'b1,32'h40,  C_RST,32'h0,   2'd0,2'd0,2'd0);
    vec("idle0",    1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h0,   C_DEF,32'h0,   2'd0,2'd0,2'd0);
    vec("lu_rs",    1'b0,1'b0,5'd5,5'd0,1'b0,5'd5,4'b0000,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd0,2'd0,2'd0);
    vec("after_lu", 1'b0,1'b0,5'd5,5'd0,1'b0,5'd5,4'b0000,4'b0000,1'b0,32'h0,   C_DEF,32'h0,   2'd1,2'd0,2'd0);
    vec("lu_r0",    1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0010,1'b0,32'h0,   C_DEF,32'h0,   2'd1,2'd0,2'd0);
    vec("lu_rt",    1'b0,1'b0,5'd3,5'd7,1'b1,5'd7,4'b0000,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd1,2'd0,2'd0);
    vec("rt_unused",1'b0,1'b0,5'd3,5'd7,1'b0,5'd7,4'b0000,4'b0010,1'b0,32'h0,   C_DEF,32'h0,   2'd2,2'd0,2'd0);
    vec("beq_id",   1'b0,1'b0,5'd1,5'd2,1'b0,5'd0,4'b0100,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd2,2'd0,2'd0);
    vec("beq_tk",   1'b0,1'b0,5'd5,5'd0,1'b0,5'd5,4'b0100,4'b0110,1'b1,32'h40,  C_TK, 32'h40,  2'd2,2'd1,2'd0);
    vec("post_tk",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h40,  C_DEF,32'h0,   2'd2,2'd1,2'd1);
    vec("bne_id",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b1000,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd2,2'd1,2'd1);
    vec("bne_nt",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b1000,1'b1,32'h80,  C_DEF,32'h0,   2'd2,2'd2,2'd1);
    vec("post_nt",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h0,   C_DEF,32'h0,   2'd2,2'd2,2'd1);
    vec("ldbr_stl", 1'b0,1'b0,5'd9,5'd0,1'b0,5'd9,4'b0100,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd2,2'd2,2'd1);
    vec("ldbr_id",  1'b0,1'b0,5'd9,5'd0,1'b0,5'd0,4'b0100,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd3,2'd2,2'd1);
    vec("ldbr_tk",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b1000,1'b0,32'h100, C_TK, 32'h100, 2'd3,2'd3,2'd1);
    vec("bad_id",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0100,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd3,2'd3,2'd2);
    vec("bad_ex",   1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b1,32'h44,  C_DEF,32'h0,   2'd3,2'd3,2'd2);
    vec("lu_sat",   1'b0,1'b0,5'd4,5'd0,1'b0,5'd4,4'b0000,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd3,2'd3,2'd2);
    vec("lu_clr",   1'b0,1'b1,5'd4,5'd0,1'b0,5'd4,4'b0000,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd3,2'd3,2'd2);
    vec("cleared",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h0,   C_DEF,32'h0,   2'd0,2'd0,2'd0);
    vec("lu_again", 1'b0,1'b0,5'd4,5'd0,1'b0,5'd4,4'b0000,4'b0010,1'b0,32'h0,   C_LU, 32'h0,   2'd0,2'd0,2'd0);
    vec("br_pre_rst",1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0100,4'b0000,1'b0,32'h0,  C_BID,32'h0,   2'd1,2'd0,2'd0);
    vec("rst_midbr",1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0100,1'b1,32'h40,  C_RST,32'h0,   2'd1,2'd1,2'd0);
    vec("rst_rel",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0100,1'b1,32'h40,  C_DEF,32'h0,   2'd0,2'd0,2'd0);
    vec("b2b_1id",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0100,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd0,2'd0,2'd0);
    vec("b2b_1ex",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b1000,4'b0100,1'b0,32'h20,  C_DEF,32'h0,   2'd0,2'd1,2'd0);
    vec("b2b_2id",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b1000,4'b0000,1'b0,32'h0,   C_BID,32'h0,   2'd0,2'd1,2'd0);
    vec("b2b_2ex",  1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b1000,1'b1,32'h24,  C_DEF,32'h0,   2'd0,2'd2,2'd0);
    vec("final",    1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,4'b0000,4'b0000,1'b0,32'h0,   C_DEF,32'h0,   2'd0,2'd2,2'd0);
    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
